serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
- Serial-in, parallel-out stage that sits directly upstream of the write-enable register.
- Collects a framed bit stream into a WIDTH-bit word.
- Presents the word on out together with a one-cycle out_valid pulse; out_valid drives the register's en input and out drives its in input.
- Captures one word per frame. Frames are started by a start strobe and paced by sin_valid.

Parameters:
- WIDTH, 8: number of data bits per frame (must be ≥2).
- MSB_FIRST, 1: 1 means the first received bit lands in out[WIDTH-1]; 0 means it lands in out[0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  frame-start strobe, sampled on the clock edge.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a valid bit this cycle.
- out  output  WIDTH  last completed word; feeds register en/in pair.
- out_valid  output  1  one-cycle pulse when out has just been updated.
- busy  output  1  frame in progress (FSM not IDLE).
- parity_err  output  1  parity result of the last frame; constant 0 unless PARITY_EN is defined.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, bit counter=0, shift reg=0, out=0, out_valid=0, busy=0, parity_err=0. Reset mid-frame discards the partial word.
- All state and outputs are registered; no combinational path from inputs to outputs.
- Bit counter width is clog2(WIDTH)+1. Bits are only counted in cycles with sin_valid=1; sin is ignored when sin_valid=0.
- IDLE:
  - busy=0; sin and sin_valid are ignored.
  - start=1 → SHIFT, counter=0.
  - The start cycle never samples a data bit, even if sin_valid=1.
- SHIFT:
  - busy=1.
  - Each sin_valid=1 cycle shifts sin into the shift register per MSB_FIRST and increments the counter.
  - On the cycle the WIDTH-th bit is sampled (counter==WIDTH-1 and sin_valid=1), the frame completes:
    - next edge: out ← assembled word (including that final bit), out_valid=1 for exactly one cycle.
    - state → IDLE, or SHIFT with counter=0 if start=1 in that same cycle (back-to-back frames).
- start=1 in SHIFT on a non-final cycle: abort. The partial word is discarded, counter=0, state stays SHIFT, out and out_valid are untouched. A bit presented with sin_valid in that cycle is not sampled.
- Latency: out_valid rises on the clock edge that samples the final bit (one edge after that bit is presented). Minimum frame is WIDTH+1 cycles (start + WIDTH bits).
- out holds its value between frames; only a completed frame changes it.
- out_valid is never asserted two cycles in a row.

Optional Feature:
- Macro: SERIAL_DESERIALIZER_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit the FSM enters PARITY instead of completing; busy stays 1.
  - The next sin_valid=1 cycle samples an even-parity bit p.
  - Frame then completes: out ← word, out_valid pulse, parity_err ← (^word) ^ p, registered and updated together with out.
  - start in PARITY: aborts the frame exactly as in SHIFT, unless it coincides with the parity-sample cycle, in which case it starts a back-to-back frame.
  - Minimum frame is WIDTH+2 cycles.
- Undefined: no PARITY state; parity_err tied to 0; behaviour as above.

Test Plan:
- Reset, then hold reset=0 mid-frame after 3 bits → out=8'h00, out_valid=0, busy=0; a fresh frame afterwards completes normally.
- MSB_FIRST=1: start, then bits 1,0,1,1,0,0,1,0 with sin_valid=1 each cycle → out=8'hB2 and out_valid=1 for one cycle on the edge after the 8th bit; busy=0 next.
- Gapped sin_valid: same frame as above with sin_valid=0 in every other cycle (sin toggling randomly during gaps) → out=8'hB2; no early out_valid.
- Abort: start, 4 bits 1111, start again, then 8'h3C serially → single out_valid with out=8'h3C; no pulse for the partial frame.
- Back-to-back: start asserted together with the final bit of 8'hA5, then 8'h5A → two out_valid pulses exactly 8 cycles apart, values A5 then 5A; out unchanged between.
- PARITY_EN defined: 8'hB2 (four 1s) followed by p=0 → parity_err=0; repeat with p=1 → parity_err=1, out=8'hB2 both times.

Source files
------------

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//
// Serial-in, parallel-out stage feeding a write-enable register. A frame is
// opened by a start strobe; data bits are taken only in cycles where sin_valid
// is high. Once WIDTH bits have arrived the assembled word is presented on
// out, together with a one-cycle out_valid pulse. out_valid drives the
// register's enable and out drives its data input.
//
// Optional feature (macro SERIAL_DESERIALIZER_PARITY_EN):
//   When defined, the WIDTH data bits are followed by one even-parity bit.
//   parity_err is updated together with out when the frame completes. When the
//   macro is undefined, parity_err is held at 0.
//
// Parameters:
//   WIDTH     - data bits per frame (>= 2)
//   MSB_FIRST - 1: first received bit lands in out[WIDTH-1]; 0: in out[0]
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   frame-start strobe (also aborts a frame in progress)
//   sin        in   serial data bit
//   sin_valid  in   sin carries a valid bit this cycle
//   out        out  last completed word (registered)
//   out_valid  out  one-cycle pulse when out has just been updated
//   busy       out  a frame is in progress
//   parity_err out  parity result of the last completed frame
// -----------------------------------------------------------------------------
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } state_t;

  // Even parity over a data word: 1 when the word has an odd number of ones.
  function automatic logic word_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_s;
  logic             out_valid_r;
  logic             out_valid_s;
  logic             busy_r;
  logic             busy_s;
  logic             parity_err_r;
  logic             parity_err_s;

  // Shift register contents after accepting sin in the configured bit order.
  always_comb begin
    shifted_s = shreg_r;
    if (MSB_FIRST) begin
      shifted_s = {shreg_r[WIDTH-2:0], sin};
    end else begin
      shifted_s = {sin, shreg_r[WIDTH-1:1]};
    end
  end

  // Next-state and next-output logic for the framing FSM.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    shreg_s      = shreg_r;
    out_s        = out_r;
    out_valid_s  = 1'b0;
    parity_err_s = parity_err_r;

    case (state_r)
      IDLE: begin
        // sin/sin_valid are ignored here; the start cycle never samples a bit.
        if (start) begin
          state_s = SHIFT;
          cnt_s   = '0;
          shreg_s = '0;
        end else begin
          state_s = IDLE;
        end
      end

      SHIFT: begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        // The last data bit is not a completion here, so start always aborts.
        if (start) begin
          state_s = SHIFT;
          cnt_s   = '0;
          shreg_s = '0;
        end else if (sin_valid) begin
          shreg_s = shifted_s;
          if (cnt_r == LAST_IDX) begin
            state_s = PARITY;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = SHIFT;
        end
`else
        // Completion takes priority over start: start then opens the next frame.
        if (sin_valid && (cnt_r == LAST_IDX)) begin
          out_s       = shifted_s;
          out_valid_s = 1'b1;
          cnt_s       = '0;
          shreg_s     = '0;
          if (start) begin
            state_s = SHIFT;
          end else begin
            state_s = IDLE;
          end
        end else if (start) begin
          state_s = SHIFT;
          cnt_s   = '0;
          shreg_s = '0;
        end else if (sin_valid) begin
          shreg_s = shifted_s;
          cnt_s   = cnt_r + CW'(1);
        end else begin
          state_s = SHIFT;
        end
`endif
      end

`ifdef SERIAL_DESERIALIZER_PARITY_EN
      PARITY: begin
        if (sin_valid) begin
          out_s        = shreg_r;
          out_valid_s  = 1'b1;
          parity_err_s = word_parity(shreg_r) ^ sin;
          cnt_s        = '0;
          shreg_s      = '0;
          if (start) begin
            state_s = SHIFT;
          end else begin
            state_s = IDLE;
          end
        end else if (start) begin
          state_s = SHIFT;
          cnt_s   = '0;
          shreg_s = '0;
        end else begin
          state_s = PARITY;
        end
      end
`endif

      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        shreg_s = '0;
      end
    endcase

`ifndef SERIAL_DESERIALIZER_PARITY_EN
    parity_err_s = 1'b0;
`endif
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      shreg_r      <= '0;
      out_r        <= '0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      shreg_r      <= shreg_s;
      out_r        <= out_s;
      out_valid_r  <= out_valid_s;
      busy_r       <= busy_s;
      parity_err_r <= parity_err_s;
    end
  end

  assign out        = out_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign parity_err = parity_err_r;

endmodule

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
//
// Drives two deserializers (MSB-first and LSB-first) with the same directed
// stimulus. A frame-level model (a list of received bits placed into a word
// when the frame closes) predicts every output each cycle, and directed
// literal checks pin the model on the hand-computed words.
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

  localparam int W = 8;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sin;
  logic         sin_valid;
  logic [W-1:0] out1, out0;
  logic         ov1, ov0, busy1, busy0, pe1, pe0;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .start(start), .sin(sin), .sin_valid(sin_valid),
    .out(out1), .out_valid(ov1), .busy(busy1), .parity_err(pe1)
  );

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .start(start), .sin(sin), .sin_valid(sin_valid),
    .out(out0), .out_valid(ov0), .busy(busy0), .parity_err(pe0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic         m_active;
  int           m_n;
  logic [W-1:0] m_bits;   // m_bits[i] = i-th received bit of the frame
  logic [W-1:0] e_out1, e_out0;
  logic         e_ov, e_pe;

  // Place received bits into a word; optionally the final bit arrives now.
  function automatic logic [W-1:0] place(input logic [W-1:0] b, input logic lastbit,
                                         input bit fin, input bit msb);
    logic [W-1:0] r;
    r = '0;
    if (fin) b[W-1] = lastbit;
    for (int i = 0; i < W; i++) begin
      if (msb) r[W-1-i] = b[i];
      else     r[i]     = b[i];
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0; m_n <= 0; m_bits <= '0;
      e_out1 <= '0; e_out0 <= '0; e_ov <= 1'b0; e_pe <= 1'b0;
    end else begin
      e_ov <= 1'b0;
      if (!m_active) begin
        if (start) begin m_active <= 1'b1; m_n <= 0; end
      end else if (PAR && m_n == W) begin
        if (sin_valid) begin
          e_out1 <= place(m_bits, 1'b0, 1'b0, 1'b1);
          e_out0 <= place(m_bits, 1'b0, 1'b0, 1'b0);
          e_pe   <= (^m_bits) ^ sin;
          e_ov   <= 1'b1;
          m_active <= start;
          m_n <= 0;
        end else if (start) begin
          m_n <= 0;
        end
      end else if (!PAR && sin_valid && m_n == W - 1) begin
        e_out1 <= place(m_bits, sin, 1'b1, 1'b1);
        e_out0 <= place(m_bits, sin, 1'b1, 1'b0);
        e_pe   <= 1'b0;
        e_ov   <= 1'b1;
        m_active <= start;
        m_n <= 0;
      end else if (start) begin
        m_n <= 0;
      end else if (sin_valid) begin
        m_bits[m_n] <= sin;
        m_n <= m_n + 1;
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_out_msb",  {24'h0, out1}, {24'h0, e_out1});
      chk("cyc_out_lsb",  {24'h0, out0}, {24'h0, e_out0});
      chk("cyc_ov_msb",   {31'h0, ov1},  {31'h0, e_ov});
      chk("cyc_ov_lsb",   {31'h0, ov0},  {31'h0, e_ov});
      chk("cyc_busy_msb", {31'h0, busy1}, {31'h0, m_active});
      chk("cyc_busy_lsb", {31'h0, busy0}, {31'h0, m_active});
      chk("cyc_pe_msb",   {31'h0, pe1},  {31'h0, e_pe});
      chk("cyc_pe_lsb",   {31'h0, pe0},  {31'h0, e_pe});
    end
  end

  // Pulse log (cycle number and value) for spacing/count checks.
  int           cyc_n = 0;
  int           pulse_cyc[$];
  logic [W-1:0] pulse_val[$];
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) begin
    if (ov1) begin
      pulse_cyc.push_back(cyc_n);
      pulse_val.push_back(out1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic s, input logic v, input logic b);
    @(negedge clk);
    start = s; sin_valid = v; sin = b;
  endtask

  // Send a frame's bits MSB of d first; parity bit p follows when enabled.
  // sol puts start on the frame's final cycle.
  task automatic send(input logic [W-1:0] d, input bit gap, input bit sol, input logic p);
    for (int i = W - 1; i >= 0; i--) begin
      if (gap) cyc(1'b0, 1'b0, 1'($urandom_range(1, 0)));
      cyc(!PAR && sol && (i == 0), 1'b1, d[i]);
    end
    if (PAR) begin
      if (gap) cyc(1'b0, 1'b0, 1'($urandom_range(1, 0)));
      cyc(sol, 1'b1, p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    reset = 1'b0; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out",  {24'h0, out1}, 32'h0);
    chk("rst_ov",   {31'h0, ov1},  32'h0);
    chk("rst_busy", {31'h0, busy1}, 32'h0);
    chk("rst_pe",   {31'h0, pe1},  32'h0);
    cmp_en = 1'b1;
    reset = 1'b1;

    // Idle ignores sin_valid.
    cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0);

    // Reset mid-frame after 3 bits.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1);
    @(negedge clk); start = 1'b0; sin_valid = 1'b0;
    chk("mid_busy_before", {31'h0, busy1}, 32'h1);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("midrst_out",  {24'h0, out1}, 32'h0);
    chk("midrst_ov",   {31'h0, ov1},  32'h0);
    chk("midrst_busy", {31'h0, busy1}, 32'h0);
    reset = 1'b1;

    // Fresh frame B2, contiguous.
    cyc(1'b1, 1'b0, 1'b0);
    send(8'hB2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("b2_out_msb", {24'h0, out1}, 32'hB2);
    chk("b2_out_lsb", {24'h0, out0}, 32'h4D);
    chk("b2_ov",      {31'h0, ov1},  32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("b2_ov_drop", {31'h0, ov1},  32'h0);
    chk("b2_busy",    {31'h0, busy1}, 32'h0);

    // Abort after 1111, restart (bit in start cycle ignored), then 3C.
    n0 = pulse_cyc.size();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_out", {24'h0, out1}, 32'h3C);
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_pulses", pulse_cyc.size() - n0, 32'd1);

    // Gapped B2 with start carrying sin_valid in idle.
    cyc(1'b1, 1'b1, 1'b1);
    send(8'hB2, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("gap_out_msb", {24'h0, out1}, 32'hB2);
    chk("gap_out_lsb", {24'h0, out0}, 32'h4D);
    chk("gap_ov",      {31'h0, ov1},  32'h1);

    // Back-to-back A5 then 5A.
    cyc(1'b0, 1'b0, 1'b0);
    n0 = pulse_cyc.size();
    cyc(1'b1, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b1, 1'b0);
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    chk("b2b_pulses", pulse_cyc.size() - n0, 32'd2);
    if (pulse_cyc.size() >= n0 + 2) begin
      chk("b2b_spacing", pulse_cyc[n0+1] - pulse_cyc[n0], W + int'(PAR));
      chk("b2b_first",   {24'h0, pulse_val[n0]},   32'hA5);
      chk("b2b_second",  {24'h0, pulse_val[n0+1]}, 32'h5A);
    end
    chk("b2b_busy", {31'h0, busy1}, 32'h0);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    cyc(1'b1, 1'b0, 1'b0);
    send(8'hB2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("par0_out", {24'h0, out1}, 32'hB2);
    chk("par0_pe",  {31'h0, pe1},  32'h0);
    cyc(1'b1, 1'b0, 1'b0);
    send(8'hB2, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("par1_out", {24'h0, out1}, 32'hB2);
    chk("par1_pe",  {31'h0, pe1},  32'h1);
`else
    chk("nopar_pe", {31'h0, pe1}, 32'h0);
`endif

    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
